// File: rtl/rocketcpu_gpio_ctrl_if.sv
// rocketcpu_gpio_ctrl_if: Wishbone slave bus bundle for the GPIO controller
interface rocketcpu_gpio_ctrl_if;
  logic [1:0]  adr;
  logic [31:0] dat;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  modport master (output adr, dat, we, cyc, input rdt, ack);
  modport slave (input adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/rocketcpu_gpio_ctrl.sv
// rocketcpu_gpio_ctrl: Wishbone GPIO controller (LED blink, button debounce, press events; ROCKETCPU_GPIO_IRQ_EN enables masked irq)
module rocketcpu_gpio_ctrl #(
  parameter int          DB_CYCLES  = 50000,
  parameter logic [23:0] PERIOD_RST = 24'd6000000
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst,
  rocketcpu_gpio_ctrl_if.slave  wb,
  input  logic [3:0]            i_gpio,
  output logic                  o_gpio,
  output logic                  o_irq
);
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  logic          accept, wr;
  logic          led, mode, phase;
  logic [3:0]    mask;
  logic [23:0]   period, per_last, cnt;
  logic [3:0]    sync1, sync2, db, db_nxt, rise, evt, clr;
  logic [CW-1:0] db_cnt [4];
  logic [CW-1:0] db_cnt_nxt [4];
  logic [31:0]   rd_val;
  logic          unused_dat;
  assign unused_dat = ^wb.dat[31:24];
  assign accept = wb.cyc & ~wb.ack;
  assign wr = accept & wb.we;
  assign per_last = period == 24'd0 ? 24'd0 : period - 24'd1;
  assign clr = (wr && wb.adr == 2'd3) ? wb.dat[3:0] : 4'd0;
  assign rise = db_nxt & ~db;
  assign rd_val = wb.adr == 2'd0 ? {20'd0, mask, 6'd0, mode, led} :
                  wb.adr == 2'd1 ? {8'd0, period} :
                  wb.adr == 2'd2 ? {24'd0, sync2, db} : {28'd0, evt};
  // bus handshake: one-cycle ack per accepted request, read data captured with it
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) begin
      wb.ack <= 1'b0;
      wb.rdt <= '0;
    end else begin
      wb.ack <= accept;
      if (accept) wb.rdt <= wb.we ? 32'd0 : rd_val;
    end
  // control, period and sticky press-event registers; a new press beats a same-edge clear
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) begin
      led    <= 1'b0;
      mode   <= 1'b0;
      period <= PERIOD_RST;
      evt    <= 4'd0;
    end else begin
      if (wr && wb.adr == 2'd0) begin
        led  <= wb.dat[0];
        mode <= wb.dat[1];
      end
      if (wr && wb.adr == 2'd1) period <= wb.dat[23:0];
      evt <= (evt & ~clr) | rise;
    end
`ifdef ROCKETCPU_GPIO_IRQ_EN
  // interrupt mask storage
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) mask <= 4'd0;
    else if (wr && wb.adr == 2'd0) mask <= wb.dat[11:8];
  // registered level interrupt from masked events
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) o_irq <= 1'b0;
    else o_irq <= |(evt & mask);
`else
  assign mask = 4'd0;
  assign o_irq = 1'b0;
`endif
  // blink engine: counter wraps at max(period,1)-1 and toggles phase; held idle in direct mode
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst || !mode) begin
      cnt   <= 24'd0;
      phase <= 1'b0;
    end else if (wr && wb.adr == 2'd1) cnt <= 24'd0;
    else if (cnt >= per_last) begin
      cnt   <= 24'd0;
      phase <= ~phase;
    end else cnt <= cnt + 24'd1;
  // LED output: phase is 0 in direct mode, so this covers both modes
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) o_gpio <= 1'b0;
    else o_gpio <= phase ^ led;
  // two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
    end else begin
      sync1 <= i_gpio;
      sync2 <= sync1;
    end
  // debounce: accept the synchronized level once it has differed for DB_CYCLES clocks
  always_comb begin
    db_nxt = db;
    for (int i = 0; i < 4; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != db[i]) begin
        if (db_cnt[i] == DB_LAST) db_nxt[i] = sync2[i];
        else db_cnt_nxt[i] = db_cnt[i] + 1'b1;
      end
    end
  end
  // debounced state and per-button stability counters
  always_ff @(posedge i_wb_clk)
    if (i_wb_rst) begin
      db <= 4'd0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      db <= db_nxt;
      for (int i = 0; i < 4; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
endmodule

// File: tb/tb_rocketcpu_gpio_ctrl.sv
// tb_rocketcpu_gpio_ctrl: randomized directed bench with a behavioural register/button model
module tb_rocketcpu_gpio_ctrl;
  localparam int DB = 8;
`ifdef ROCKETCPU_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] CTRL_MASK = IRQ_EN ? 32'hF03 : 32'h3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] gpio_in = 4'd0;
  logic gpio_out, irq;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_ctrl, rd, v, c;
  logic [23:0] m_period;
  logic [3:0] m_evt;
  int p, pe, b, len;

  rocketcpu_gpio_ctrl_if bus();
  rocketcpu_gpio_ctrl #(.DB_CYCLES(DB)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .wb(bus),
    .i_gpio(gpio_in), .o_gpio(gpio_out), .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input bit we, input logic [1:0] adr, input logic [31:0] dat, output logic [31:0] rdt);
    bit seen;
    seen = 1'b0;
    bus.cyc = 1'b1;
    bus.we = we;
    bus.adr = adr;
    bus.dat = dat;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = bus.ack;
    end
    rdt = bus.rdt;
    bus.cyc = 1'b0;
    bus.we = 1'b0;
    check("ack_seen", 32'(seen), 32'd1);
  endtask

  function automatic logic exp_irq();
    return IRQ_EN && (|(m_evt & m_ctrl[11:8]));
  endfunction

  task automatic press(input int bit_i, input int l);
    gpio_in[bit_i] = 1'b1;
    tick(l);
    gpio_in[bit_i] = 1'b0;
    tick(DB + 4);
  endtask

  initial begin
    bus.cyc = 1'b0;
    bus.we = 1'b0;
    bus.adr = 2'd0;
    bus.dat = 32'd0;
    tick(3);
    check("rst_gpio", 32'(gpio_out), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_rdt", bus.rdt, 0);
    check("rst_irq", 32'(irq), 0);
    rst = 1'b0;
    m_ctrl = 0;
    m_period = 24'h5B8D80;
    m_evt = 0;
    xfer(0, 0, 0, rd); check("rd_ctrl", rd, m_ctrl);
    xfer(0, 1, 0, rd); check("rd_period", rd, {8'd0, m_period});
    xfer(0, 2, 0, rd); check("rd_btn", rd, 0);
    xfer(0, 3, 0, rd); check("rd_evt", rd, {28'd0, m_evt});
    tick(1);
    check("ack_pulse", 32'(bus.ack), 0);
    bus.cyc = 1'b1;
    bus.adr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("ack_b2b", 32'(bus.ack), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.cyc = 1'b0;
    tick(1);
    xfer(1, 0, 1, rd); m_ctrl = 1;
    check("wr_rdt_zero", rd, 0);
    check("gpio_before", 32'(gpio_out), 0);
    tick(1);
    check("gpio_on", 32'(gpio_out), 1);
    xfer(1, 0, 0, rd); m_ctrl = 0;
    tick(1);
    check("gpio_off", 32'(gpio_out), 0);
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      xfer(1, 1, v, rd); m_period = v[23:0];
      xfer(0, 1, 0, rd); check("period_rb", rd, {8'd0, m_period});
      v = $urandom;
      xfer(1, 0, v, rd); m_ctrl = v & CTRL_MASK;
      xfer(0, 0, 0, rd); check("ctrl_rb", rd, m_ctrl);
      xfer(1, 2, v, rd);
      xfer(0, 2, 0, rd); check("btn_ro", rd, 0);
    end
    for (int t = 0; t < 5; t++) begin
      p = (t == 0) ? 4 : (t == 1) ? 0 : $urandom_range(1, 6);
      c = (t % 2 == 1) ? 32'd3 : 32'd2;
      pe = (p == 0) ? 1 : p;
      xfer(1, 0, 0, rd);
      xfer(1, 1, p, rd); m_period = 24'(p);
      xfer(1, 0, c, rd); m_ctrl = c;
      for (int n = 1; n <= 3 * pe + 1; n++) begin
        tick(1);
        check("blink", 32'(gpio_out), 32'(c[0] ^ (((n - 1) / pe) % 2 == 1)));
      end
    end
    xfer(1, 0, 0, rd); m_ctrl = 0;
    tick(1);
    check("blink_stop", 32'(gpio_out), 0);
    press(2, 5);
    xfer(0, 2, 0, rd); check("glitch_btn", rd, 0);
    xfer(0, 3, 0, rd); check("glitch_evt", rd, {28'd0, m_evt});
    gpio_in[2] = 1'b1;
    tick(DB + 1);
    xfer(0, 3, 0, rd); check("evt_early", rd, {28'd0, m_evt});
    m_evt[2] = 1'b1;
    xfer(0, 3, 0, rd); check("evt_set", rd, {28'd0, m_evt});
    xfer(0, 2, 0, rd); check("btn_held", rd, 32'h44);
    tick(8);
    gpio_in[2] = 1'b0;
    tick(DB + 4);
    xfer(0, 3, 0, rd); check("evt_release", rd, {28'd0, m_evt});
    xfer(0, 2, 0, rd); check("btn_released", rd, 0);
    gpio_in[2] = 1'b1;
    tick(DB + 1);
    xfer(1, 3, 4, rd);
    xfer(0, 3, 0, rd); check("evt_race", rd, {28'd0, m_evt});
    gpio_in[2] = 1'b0;
    tick(DB + 4);
    xfer(1, 3, 4, rd); m_evt[2] = 1'b0;
    xfer(0, 3, 0, rd); check("evt_clear", rd, {28'd0, m_evt});
    xfer(1, 0, 32'h400, rd); m_ctrl = 32'h400 & CTRL_MASK;
    gpio_in[2] = 1'b1;
    tick(DB + 2);
    check("irq_lag", 32'(irq), 32'(exp_irq()));
    m_evt[2] = 1'b1;
    tick(1);
    check("irq_set", 32'(irq), 32'(exp_irq()));
    gpio_in[2] = 1'b0;
    tick(DB + 4);
    xfer(1, 3, 4, rd); m_evt[2] = 1'b0;
    tick(1);
    check("irq_clear", 32'(irq), 32'(exp_irq()));
    xfer(1, 0, 0, rd); m_ctrl = 0;
    press(2, 2 * DB); m_evt[2] = 1'b1;
    check("irq_masked", 32'(irq), 32'(exp_irq()));
    xfer(1, 3, 4, rd); m_evt[2] = 1'b0;
    m_ctrl = 32'($urandom) & 32'h00000F00 & CTRL_MASK;
    xfer(1, 0, m_ctrl, rd);
    for (int i = 0; i < 8; i++) begin
      b = $urandom_range(0, 3);
      len = (i == 0) ? DB - 1 : (i == 1) ? DB : $urandom_range(1, 2 * DB);
      press(b, len);
      if (len >= DB) m_evt[b] = 1'b1;
      xfer(0, 3, 0, rd); check("rnd_evt", rd, {28'd0, m_evt});
      xfer(0, 2, 0, rd); check("rnd_btn", rd, 0);
      check("rnd_irq", 32'(irq), 32'(exp_irq()));
      v = $urandom_range(0, 15);
      xfer(1, 3, v, rd); m_evt = m_evt & ~v[3:0];
      xfer(0, 3, 0, rd); check("rnd_w1c", rd, {28'd0, m_evt});
      check("rnd_irq_w1c", 32'(irq), 32'(exp_irq()));
    end
    gpio_in[0] = 1'b1;
    bus.cyc = 1'b1;
    bus.adr = 2'd0;
    rst = 1'b1;
    tick(1);
    check("rst_mid_ack", 32'(bus.ack), 0);
    bus.cyc = 1'b0;
    tick(1);
    rst = 1'b0;
    m_ctrl = 0;
    m_period = 24'h5B8D80;
    m_evt = 0;
    tick(DB + 1);
    xfer(0, 3, 0, rd); check("rst_held_early", rd, {28'd0, m_evt});
    m_evt[0] = 1'b1;
    xfer(0, 3, 0, rd); check("rst_held_evt", rd, {28'd0, m_evt});
    xfer(0, 1, 0, rd); check("rst_period", rd, {8'd0, m_period});
    check("rst_gpio2", 32'(gpio_out), 0);
    gpio_in[0] = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
